lq_mem_ctrl: RTL and testbench
==============================

// Module: lq_mem_ctrl
// PURPOSE
//  Memory-port controller for the load queue. Arbitrates one proc2mem port between the LQ head and the store-retire port.
//  Tracks loads that memory accepted, by mem tag, until their data returns, then broadcasts the data with dest_reg.
//  Sits between the LQ/store retire logic and the memory interface. Owns LQ pop and store ack.
// PARAMETERS
//  MAX_OUTSTANDING  4   in-flight loads tracked; 1..15
//  STARVE_LIMIT     8   cycles a blocked LQ head waits before forced load grant (fixed-priority mode only)
//  DEST_W           5   dest_reg width; DUMMY_REG = all ones
// PORTS
//  clock              in   1       system clock
//  reset              in   1       synchronous, active-high
//  lq_valid           in   1       LQ head holds a load (LQ read_valid)
//  lq_addr            in   64      LQ head address (alu_result)
//  lq_dest            in   DEST_W  LQ head dest_reg
//  lq_pop             out  1       comb; pop LQ head this cycle
//  st_valid           in   1       retiring store request
//  st_addr            in   64      store address
//  st_data            in   64      store data
//  st_ack             out  1       comb; store accepted this cycle
//  proc2mem_command   out  2       comb; BUS_NONE/BUS_LOAD/BUS_STORE
//  proc2mem_addr      out  64      comb; granted requester address, 0 when idle
//  proc2mem_data      out  64      comb; st_data when store granted, else 0
//  mem2proc_response  in   4       accept tag, same cycle; 0 = rejected
//  mem2proc_data      in   64      returning load data
//  mem2proc_tag       in   4       tag of returning data; 0 = none
//  ld_done_valid      out  1       reg; load data valid
//  ld_done_dest       out  DEST_W  reg; dest_reg of completed load
//  ld_done_data       out  64      reg; completed load data
//  outstanding        out  4       reg; live table entries
//  lq_blocked         out  1       comb; lq_valid and table full
// BEHAVIOUR
//  Reset: table cleared, outstanding=0, ld_done_valid=0, ld_done_dest=DUMMY_REG, ld_done_data=0, starve_cnt=0, rr_ptr=0.
//  Mid-operation reset flushes the table. Tags returning after reset match no entry and are ignored.
//  Eligibility: a load is eligible iff lq_valid && outstanding<MAX_OUTSTANDING. A store is eligible iff st_valid.
//  Arbitration is comb, one grant per cycle. With no grant: command=BUS_NONE, addr=0, data=0.
//  Fixed priority: store wins, except a load wins when starve_cnt>=STARVE_LIMIT.
//  starve_cnt: +1 (saturating) each cycle an eligible load loses; cleared on load acceptance.
//  Acceptance: mem2proc_response!=0 in the grant cycle. Response 0 means no pop and no ack; retry next cycle.
//  Load accepted -> lq_pop=1; entry {valid,tag=response,dest=lq_dest} is written into the lowest free slot at the clock edge.
//  Store accepted -> st_ack=1; no table entry.
//  Completion: mem2proc_tag!=0 matching a valid entry.
//    Next cycle: ld_done_valid=1, ld_done_dest=entry.dest, ld_done_data=mem2proc_data, and the entry is freed.
//    Completion latency is 1 cycle. A non-matching tag is ignored and ld_done_valid=0.
//  Same-cycle allocate and complete is legal. Net outstanding is unchanged.
//    Fullness for eligibility uses the pre-edge count, so a slot freed this cycle is not reusable this cycle.
//  Allocating a tag already live is an error: simulation $error, and the new entry overwrites the old match.
//  outstanding never exceeds MAX_OUTSTANDING and never underflows.
// CONFIGURATION
//  LQ_MEM_CTRL_RR_EN defined: replaces fixed priority with round-robin.
//    rr_ptr (1 bit) names the preferred requester. It flips only on an accepted grant.
//    starve_cnt is not built; STARVE_LIMIT is ignored.
//  Undefined: fixed store priority plus the starvation counter described above.
// STRUCTURE
//  sys_defs package/header: BUS_NONE/BUS_LOAD/BUS_STORE encodings, DUMMY_REG, LQ_MEM_ENTRY_T {valid,tag[3:0],dest[DEST_W-1:0]}.
//  Sub-module mem_tag_table: MAX_OUTSTANDING entries.
//    Inputs: alloc_en/tag/dest, match_tag.
//    Outputs: hit, hit_dest, full, count.
//    Free on hit is registered.
//  Top level holds the arbiter, starve_cnt/rr_ptr, and the ld_done output registers.
// TESTING
//  Load only: lq_valid=1, addr=0x100, dest=3, response=5 -> lq_pop=1, outstanding=1.
//    Later tag=5, data=0xABCD -> next cycle ld_done_valid=1, dest=3, data=0xABCD, outstanding=0.
//  Contention, fixed mode: both valid, response=2 each cycle -> stores granted 8 cycles.
//    9th cycle: load granted, starve_cnt=0. With RR_EN: grants alternate store/load from reset.
//  Full table: 4 loads accepted with tags 1..4, 5th lq_valid -> lq_blocked=1, command=BUS_NONE, no pop.
//    Tag 2 returns -> next cycle the load is granted.
//  Reject: response=0 for 3 cycles -> no pop or ack, command held.
//    Response=7 -> single pop and entry tag 7.
//  Same cycle: alloc tag 6 while tag 1 returns -> ld_done for tag 1, outstanding unchanged.
//  Reset mid-flight: 2 outstanding, reset, then tag arrives -> ld_done_valid stays 0, outstanding=0.

Source files
------------

// File: rtl/lq_mem_ctrl_pkg.sv
// Shared definitions for the load-queue memory-port controller:
// bus command encodings, the dummy destination register and the
// layout of one in-flight load entry.
package lq_mem_ctrl_pkg;

    localparam int LQ_DEST_W = 5;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'b00,
        BUS_LOAD  = 2'b01,
        BUS_STORE = 2'b10
    } bus_cmd_e;

    localparam logic [LQ_DEST_W-1:0] DUMMY_REG = '1;

    // One tracked load: memory tag plus the register it will write.
    typedef struct packed {
        logic                 valid;
        logic [3:0]           tag;
        logic [LQ_DEST_W-1:0] dest;
    } lq_mem_entry_t;

endpackage

// File: rtl/lq_mem_ctrl_tag_table.sv
// Table of loads accepted by memory and still waiting for data.
// Lookup by returning tag is combinational; the matching entry is freed
// at the next clock edge. New entries go into the lowest free slot, or
// overwrite a live entry carrying the same tag (flagged in simulation).
module lq_mem_ctrl_tag_table #(
    parameter int ENTRIES = 4,
    parameter int DEST_W  = 5
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_alloc_en,
    input  logic [3:0]        i_alloc_tag,
    input  logic [DEST_W-1:0] i_alloc_dest,
    input  logic [3:0]        i_match_tag,
    output logic              o_hit,
    output logic [DEST_W-1:0] o_hit_dest,
    output logic              o_full,
    output logic [3:0]        o_count
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [ENTRIES-1:0] r_valid;
    logic [3:0]         r_tag  [ENTRIES];
    logic [DEST_W-1:0]  r_dest [ENTRIES];
    logic [3:0]         r_count;

    logic               w_hit;
    logic [IDX_W-1:0]   w_hit_idx;
    logic               w_dup;
    logic [IDX_W-1:0]   w_dup_idx;
    logic               w_free_found;
    logic [IDX_W-1:0]   w_free_idx;
    logic [IDX_W-1:0]   w_slot;
    logic               w_wr;
    logic [ENTRIES-1:0] w_valid_nxt;
    logic [3:0]         w_count_nxt;

    // Tag lookups for completion, duplicate detection and free-slot search.
    always_comb begin
        w_hit        = 1'b0;
        w_hit_idx    = '0;
        w_dup        = 1'b0;
        w_dup_idx    = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (r_valid[i] && (i_match_tag != 4'd0) && (r_tag[i] == i_match_tag) && !w_hit) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
            if (r_valid[i] && (r_tag[i] == i_alloc_tag) && !w_dup) begin
                w_dup     = 1'b1;
                w_dup_idx = IDX_W'(i);
            end
            if (!r_valid[i] && !w_free_found) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
        end
    end

    // Next-state valid vector; an allocate into the slot being freed keeps it live.
    always_comb begin
        w_slot      = w_dup ? w_dup_idx : w_free_idx;
        w_wr        = i_alloc_en && (w_dup || w_free_found);
        w_valid_nxt = r_valid;
        if (w_hit)
            w_valid_nxt[w_hit_idx] = 1'b0;
        if (w_wr)
            w_valid_nxt[w_slot] = 1'b1;
        w_count_nxt = 4'd0;
        for (int i = 0; i < ENTRIES; i++)
            w_count_nxt = w_count_nxt + 4'(w_valid_nxt[i]);
    end

    // Valid bits and live count; reset flushes every entry.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_valid <= '0;
            r_count <= 4'd0;
        end else begin
            r_valid <= w_valid_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Entry payload; only meaningful while the matching valid bit is set.
    always_ff @(posedge i_clock) begin
        if (w_wr) begin
            r_tag[w_slot]  <= i_alloc_tag;
            r_dest[w_slot] <= i_alloc_dest;
        end
    end

`ifndef SYNTHESIS
    // Memory should never hand out a tag that is still in flight.
    always_ff @(posedge i_clock) begin
        if (!i_reset && i_alloc_en && w_dup)
            $error("lq_mem_ctrl_tag_table: tag %0d allocated while still live", i_alloc_tag);
    end
`endif

    assign o_hit      = w_hit;
    assign o_hit_dest = r_dest[w_hit_idx];
    assign o_count    = r_count;
    assign o_full     = (r_count >= 4'(ENTRIES));

endmodule

// File: rtl/lq_mem_ctrl.sv
// Load-queue memory-port controller. Arbitrates the single proc2mem port
// between the LQ head and the retiring store, tracks accepted loads by
// memory tag and broadcasts returning data with its destination register.
// Build option LQ_MEM_CTRL_RR_EN: round-robin arbitration instead of
// store priority with the load starvation counter.
module lq_mem_ctrl
    import lq_mem_ctrl_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8,
    parameter int DEST_W          = LQ_DEST_W
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_lq_valid,
    input  logic [63:0]       i_lq_addr,
    input  logic [DEST_W-1:0] i_lq_dest,
    output logic              o_lq_pop,
    input  logic              i_st_valid,
    input  logic [63:0]       i_st_addr,
    input  logic [63:0]       i_st_data,
    output logic              o_st_ack,
    output logic [1:0]        o_proc2mem_command,
    output logic [63:0]       o_proc2mem_addr,
    output logic [63:0]       o_proc2mem_data,
    input  logic [3:0]        i_mem2proc_response,
    input  logic [63:0]       i_mem2proc_data,
    input  logic [3:0]        i_mem2proc_tag,
    output logic              o_ld_done_valid,
    output logic [DEST_W-1:0] o_ld_done_dest,
    output logic [63:0]       o_ld_done_data,
    output logic [3:0]        o_outstanding,
    output logic              o_lq_blocked
);

    logic              w_full;
    logic [3:0]        w_count;
    logic              w_hit;
    logic [DEST_W-1:0] w_hit_dest;
    logic              w_ld_elig;
    logic              w_st_elig;
    logic              w_grant_load;
    logic              w_grant_store;
    logic              w_accept;

    assign w_ld_elig = i_lq_valid && !w_full;
    assign w_st_elig = i_st_valid;
    assign w_accept  = (i_mem2proc_response != 4'd0) && (w_grant_load || w_grant_store);

`ifdef LQ_MEM_CTRL_RR_EN
    logic r_rr_ptr;

    // Round robin: ptr=0 prefers the store, ptr=1 prefers the load.
    always_comb begin
        w_grant_load  = w_ld_elig && (!w_st_elig || r_rr_ptr);
        w_grant_store = w_st_elig && !w_grant_load;
    end

    // Preference toggles only when memory actually takes a request.
    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_rr_ptr <= 1'b0;
        else if (w_accept)
            r_rr_ptr <= ~r_rr_ptr;
    end
`else
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    logic [SC_W-1:0] r_starve_cnt;
    logic            w_starved;

    assign w_starved = (r_starve_cnt >= SC_W'(STARVE_LIMIT));

    // Store priority, overridden once the LQ head has waited long enough.
    always_comb begin
        w_grant_load  = w_ld_elig && (!w_st_elig || w_starved);
        w_grant_store = w_st_elig && !w_grant_load;
    end

    // Count cycles an eligible load loses arbitration; clear when a load is taken.
    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_starve_cnt <= '0;
        else if (w_grant_load && w_accept)
            r_starve_cnt <= '0;
        else if (w_ld_elig && !w_grant_load && (r_starve_cnt != '1))
            r_starve_cnt <= r_starve_cnt + 1'b1;
    end
`endif

    // Drive the memory port from whichever requester holds the grant.
    always_comb begin
        o_proc2mem_command = BUS_NONE;
        o_proc2mem_addr    = 64'd0;
        o_proc2mem_data    = 64'd0;
        if (w_grant_load) begin
            o_proc2mem_command = BUS_LOAD;
            o_proc2mem_addr    = i_lq_addr;
        end else if (w_grant_store) begin
            o_proc2mem_command = BUS_STORE;
            o_proc2mem_addr    = i_st_addr;
            o_proc2mem_data    = i_st_data;
        end
    end

    assign o_lq_pop      = w_grant_load && w_accept;
    assign o_st_ack      = w_grant_store && w_accept;
    assign o_lq_blocked  = i_lq_valid && w_full;
    assign o_outstanding = w_count;

    lq_mem_ctrl_tag_table #(
        .ENTRIES (MAX_OUTSTANDING),
        .DEST_W  (DEST_W)
    ) u_tag_table (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_alloc_en   (o_lq_pop),
        .i_alloc_tag  (i_mem2proc_response),
        .i_alloc_dest (i_lq_dest),
        .i_match_tag  (i_mem2proc_tag),
        .o_hit        (w_hit),
        .o_hit_dest   (w_hit_dest),
        .o_full       (w_full),
        .o_count      (w_count)
    );

    // Completion broadcast, one cycle after the tag matches.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_ld_done_valid <= 1'b0;
            o_ld_done_dest  <= '1;
            o_ld_done_data  <= 64'd0;
        end else begin
            o_ld_done_valid <= w_hit;
            if (w_hit) begin
                o_ld_done_dest <= w_hit_dest;
                o_ld_done_data <= i_mem2proc_data;
            end
        end
    end

endmodule

// File: tb/tb_lq_mem_ctrl.sv
// Self-checking bench for lq_mem_ctrl (default build: store priority
// with starvation override). Completed loads are predicted into a queue
// when the returning tag is driven and compared when ld_done appears.
module tb_lq_mem_ctrl;

    localparam logic [1:0] C_NONE  = 2'b00;
    localparam logic [1:0] C_LOAD  = 2'b01;
    localparam logic [1:0] C_STORE = 2'b10;

    typedef struct {
        logic [4:0]  dest;
        logic [63:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        lq_valid;
    logic [63:0] lq_addr;
    logic [4:0]  lq_dest;
    logic        lq_pop;
    logic        st_valid;
    logic [63:0] st_addr;
    logic [63:0] st_data;
    logic        st_ack;
    logic [1:0]  cmd;
    logic [63:0] maddr;
    logic [63:0] mwdata;
    logic [3:0]  resp;
    logic [63:0] mdata;
    logic [3:0]  mtag;
    logic        done_valid;
    logic [4:0]  done_dest;
    logic [63:0] done_data;
    logic [3:0]  outstanding;
    logic        blocked;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    logic [4:0] mdl_tbl [int];

    lq_mem_ctrl dut (
        .i_clock             (clk),
        .i_reset             (rst),
        .i_lq_valid          (lq_valid),
        .i_lq_addr           (lq_addr),
        .i_lq_dest           (lq_dest),
        .o_lq_pop            (lq_pop),
        .i_st_valid          (st_valid),
        .i_st_addr           (st_addr),
        .i_st_data           (st_data),
        .o_st_ack            (st_ack),
        .o_proc2mem_command  (cmd),
        .o_proc2mem_addr     (maddr),
        .o_proc2mem_data     (mwdata),
        .i_mem2proc_response (resp),
        .i_mem2proc_data     (mdata),
        .i_mem2proc_tag      (mtag),
        .o_ld_done_valid     (done_valid),
        .o_ld_done_dest      (done_dest),
        .o_ld_done_data      (done_data),
        .o_outstanding       (outstanding),
        .o_lq_blocked        (blocked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        lq_valid = 1'b0;
        st_valid = 1'b0;
        resp     = 4'd0;
        mtag     = 4'd0;
        mdata    = 64'd0;
    endtask

    task automatic test_reset();
        idle();
        lq_addr = 64'd0; lq_dest = 5'd0; st_addr = 64'd0; st_data = 64'd0;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        #1;
        n_vec++; if (done_valid !== 1'b0) begin n_err++; $display("FAIL rst_done_valid: got %0b want 0", done_valid); end
        n_vec++; if (done_dest !== 5'h1f) begin n_err++; $display("FAIL rst_done_dest: got %0h want 1f", done_dest); end
        n_vec++; if (done_data !== 64'd0) begin n_err++; $display("FAIL rst_done_data: got %0h want 0", done_data); end
        n_vec++; if (outstanding !== 4'd0) begin n_err++; $display("FAIL rst_outstanding: got %0d want 0", outstanding); end
        n_vec++; if (cmd !== C_NONE || maddr !== 64'd0 || mwdata !== 64'd0)
            begin n_err++; $display("FAIL rst_idle_bus: got cmd %0d addr %0h data %0h want 0 0 0", cmd, maddr, mwdata); end
        step();
    endtask

    task automatic test_load_only();
        exp_t e;
        lq_valid = 1'b1; lq_addr = 64'h100; lq_dest = 5'd3; resp = 4'd5;
        #1;
        n_vec++; if (lq_pop !== 1'b1) begin n_err++; $display("FAIL lo_pop: got %0b want 1", lq_pop); end
        n_vec++; if (cmd !== C_LOAD || maddr !== 64'h100 || mwdata !== 64'd0)
            begin n_err++; $display("FAIL lo_bus: got cmd %0d addr %0h data %0h want 1 100 0", cmd, maddr, mwdata); end
        mdl_tbl[5] = 5'd3;
        step();
        idle();
        n_vec++; if (outstanding !== 4'd1) begin n_err++; $display("FAIL lo_outstanding: got %0d want 1", outstanding); end
        step();
        mtag = 4'd5; mdata = 64'hABCD;
        exp_q.push_back('{5'd3, 64'hABCD});
        mdl_tbl.delete(5);
        step();
        mtag = 4'd0;
        n_vec++;
        if (done_valid !== 1'b1) begin n_err++; $display("FAIL lo_done_valid: got %0b want 1", done_valid); end
        else begin
            e = exp_q.pop_front();
            if (done_dest !== e.dest || done_data !== e.data)
                begin n_err++; $display("FAIL lo_done: got dest %0d data %0h want %0d %0h", done_dest, done_data, e.dest, e.data); end
        end
        n_vec++; if (outstanding !== 4'd0) begin n_err++; $display("FAIL lo_outstanding_after: got %0d want 0", outstanding); end
        step();
        n_vec++; if (done_valid !== 1'b0) begin n_err++; $display("FAIL lo_done_pulse: got %0b want 0", done_valid); end
    endtask

    // Return every tag the model believes is live, one per cycle.
    task automatic test_drain();
        int   keys[$];
        exp_t e;
        foreach (mdl_tbl[k]) keys.push_back(k);
        foreach (keys[j]) begin
            mtag  = 4'(keys[j]);
            mdata = {32'hD0D0_0000, 32'(keys[j])};
            exp_q.push_back('{mdl_tbl[keys[j]], mdata});
            mdl_tbl.delete(keys[j]);
            step();
            mtag = 4'd0;
            n_vec++;
            if (done_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid tag %0d: got %0b want 1", keys[j], done_valid); end
            else begin
                e = exp_q.pop_front();
                if (done_dest !== e.dest || done_data !== e.data)
                    begin n_err++; $display("FAIL drain_done tag %0d: got dest %0d data %0h want %0d %0h", keys[j], done_dest, done_data, e.dest, e.data); end
            end
            n_vec++; if (outstanding !== 4'(mdl_tbl.num()))
                begin n_err++; $display("FAIL drain_outstanding: got %0d want %0d", outstanding, mdl_tbl.num()); end
        end
    endtask

    task automatic test_contention();
        lq_valid = 1'b1; lq_addr = 64'h200; lq_dest = 5'd4;
        st_valid = 1'b1; st_addr = 64'h300; st_data = 64'h55; resp = 4'd2;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_vec++; if (st_ack !== 1'b1 || lq_pop !== 1'b0 || cmd !== C_STORE || maddr !== 64'h300 || mwdata !== 64'h55)
                begin n_err++; $display("FAIL cont_store cycle %0d: got ack %0b pop %0b cmd %0d addr %0h want 1 0 2 300", i, st_ack, lq_pop, cmd, maddr); end
            step();
        end
        #1;
        n_vec++; if (lq_pop !== 1'b1 || st_ack !== 1'b0 || cmd !== C_LOAD || maddr !== 64'h200)
            begin n_err++; $display("FAIL cont_starve_grant: got pop %0b ack %0b cmd %0d addr %0h want 1 0 1 200", lq_pop, st_ack, cmd, maddr); end
        mdl_tbl[2] = 5'd4;
        step();
        resp = 4'd3;
        #1;
        n_vec++; if (st_ack !== 1'b1 || lq_pop !== 1'b0)
            begin n_err++; $display("FAIL cont_starve_cleared: got ack %0b pop %0b want 1 0", st_ack, lq_pop); end
        step();
        idle();
        n_vec++; if (outstanding !== 4'd1) begin n_err++; $display("FAIL cont_outstanding: got %0d want 1", outstanding); end
        test_drain();
    endtask

    task automatic test_full();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            lq_valid = 1'b1; lq_addr = 64'h400 + 64'(i); lq_dest = 5'(10 + i); resp = 4'(i + 1);
            #1;
            n_vec++; if (lq_pop !== 1'b1) begin n_err++; $display("FAIL full_fill %0d: got %0b want 1", i, lq_pop); end
            mdl_tbl[i + 1] = 5'(10 + i);
            step();
        end
        lq_addr = 64'h500; lq_dest = 5'd20; resp = 4'd9;
        #1;
        n_vec++; if (outstanding !== 4'd4) begin n_err++; $display("FAIL full_count: got %0d want 4", outstanding); end
        n_vec++; if (blocked !== 1'b1 || cmd !== C_NONE || lq_pop !== 1'b0 || maddr !== 64'd0)
            begin n_err++; $display("FAIL full_blocked: got blk %0b cmd %0d pop %0b addr %0h want 1 0 0 0", blocked, cmd, lq_pop, maddr); end
        step();
        mtag = 4'd2; mdata = 64'h2222;
        #1;
        n_vec++; if (blocked !== 1'b1 || lq_pop !== 1'b0)
            begin n_err++; $display("FAIL full_no_reuse: got blk %0b pop %0b want 1 0", blocked, lq_pop); end
        exp_q.push_back('{mdl_tbl[2], 64'h2222});
        mdl_tbl.delete(2);
        step();
        mtag = 4'd0;
        n_vec++;
        if (done_valid !== 1'b1) begin n_err++; $display("FAIL full_done_valid: got %0b want 1", done_valid); end
        else begin
            e = exp_q.pop_front();
            if (done_dest !== e.dest || done_data !== e.data)
                begin n_err++; $display("FAIL full_done: got dest %0d data %0h want %0d %0h", done_dest, done_data, e.dest, e.data); end
        end
        n_vec++; if (lq_pop !== 1'b1 || blocked !== 1'b0 || cmd !== C_LOAD || maddr !== 64'h500)
            begin n_err++; $display("FAIL full_regrant: got pop %0b blk %0b cmd %0d addr %0h want 1 0 1 500", lq_pop, blocked, cmd, maddr); end
        mdl_tbl[9] = 5'd20;
        step();
        idle();
        n_vec++; if (outstanding !== 4'd4) begin n_err++; $display("FAIL full_refill: got %0d want 4", outstanding); end
        test_drain();
    endtask

    task automatic test_reject();
        lq_valid = 1'b1; lq_addr = 64'h700; lq_dest = 5'd7; resp = 4'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++; if (lq_pop !== 1'b0 || st_ack !== 1'b0 || cmd !== C_LOAD || maddr !== 64'h700)
                begin n_err++; $display("FAIL rej_hold %0d: got pop %0b ack %0b cmd %0d addr %0h want 0 0 1 700", i, lq_pop, st_ack, cmd, maddr); end
            step();
        end
        n_vec++; if (outstanding !== 4'd0) begin n_err++; $display("FAIL rej_outstanding: got %0d want 0", outstanding); end
        resp = 4'd7;
        #1;
        n_vec++; if (lq_pop !== 1'b1) begin n_err++; $display("FAIL rej_accept: got %0b want 1", lq_pop); end
        mdl_tbl[7] = 5'd7;
        step();
        idle();
        n_vec++; if (outstanding !== 4'd1) begin n_err++; $display("FAIL rej_single: got %0d want 1", outstanding); end
        test_drain();
    endtask

    task automatic test_same_cycle();
        exp_t e;
        lq_valid = 1'b1; lq_addr = 64'h800; lq_dest = 5'd9; resp = 4'd1;
        mdl_tbl[1] = 5'd9;
        step();
        lq_dest = 5'd14; resp = 4'd6; mtag = 4'd1; mdata = 64'h1111;
        #1;
        n_vec++; if (lq_pop !== 1'b1) begin n_err++; $display("FAIL same_pop: got %0b want 1", lq_pop); end
        exp_q.push_back('{mdl_tbl[1], 64'h1111});
        mdl_tbl.delete(1);
        mdl_tbl[6] = 5'd14;
        step();
        idle();
        n_vec++;
        if (done_valid !== 1'b1) begin n_err++; $display("FAIL same_done_valid: got %0b want 1", done_valid); end
        else begin
            e = exp_q.pop_front();
            if (done_dest !== e.dest || done_data !== e.data)
                begin n_err++; $display("FAIL same_done: got dest %0d data %0h want %0d %0h", done_dest, done_data, e.dest, e.data); end
        end
        n_vec++; if (outstanding !== 4'd1) begin n_err++; $display("FAIL same_outstanding: got %0d want 1", outstanding); end
        test_drain();
    endtask

    task automatic test_reset_mid();
        lq_valid = 1'b1; lq_addr = 64'h900; lq_dest = 5'd1; resp = 4'd3;
        step();
        lq_dest = 5'd2; resp = 4'd4;
        step();
        idle();
        n_vec++; if (outstanding !== 4'd2) begin n_err++; $display("FAIL mid_pre: got %0d want 2", outstanding); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        mdl_tbl.delete();
        mtag = 4'd3; mdata = 64'hDEAD;
        step();
        mtag = 4'd4;
        step();
        mtag = 4'd0;
        n_vec++; if (done_valid !== 1'b0) begin n_err++; $display("FAIL mid_done_valid: got %0b want 0", done_valid); end
        n_vec++; if (outstanding !== 4'd0) begin n_err++; $display("FAIL mid_outstanding: got %0d want 0", outstanding); end
        n_vec++; if (done_dest !== 5'h1f) begin n_err++; $display("FAIL mid_done_dest: got %0h want 1f", done_dest); end
    endtask

    initial begin
        rst = 1'b1;
        lq_valid = 1'b0; lq_addr = 64'd0; lq_dest = 5'd0;
        st_valid = 1'b0; st_addr = 64'd0; st_data = 64'd0;
        resp = 4'd0; mdata = 64'd0; mtag = 4'd0;
        test_reset();
        test_load_only();
        test_contention();
        test_full();
        test_reject();
        test_same_cycle();
        test_reset_mid();
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
